sim_run_controller: RTL and testbench

//  Parametrised run controller for the pipelined MIPS datapath. Generates the core reset,

---
 rtl/sim_run_controller.sv | 104 ++++++++++
 tb/tb_sim_run_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_controller.sv
// sim_run_controller: core reset/run sequencing with halt/timeout detection and saturating cycle/retire counters
module sim_run_controller #(
  parameter int NUM_CH       = 1,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 92,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     restart,
  input  logic [NUM_CH-1:0]        halt_in,
  input  logic [NUM_CH-1:0]        retire_valid,
  output logic                     core_reset,
  output logic                     core_run,
  output logic                     done,
  output logic                     timeout,
  output logic [NUM_CH-1:0]        halted,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [NUM_CH*CNT_W-1:0]  retire_count
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [DW-1:0] drain_cnt, drain_n;
  logic [NUM_CH-1:0] halted_n;
  logic [CNT_W-1:0] cyc_n;
  logic [NUM_CH-1:0][CNT_W-1:0] ret_q, ret_n;
  logic to_n;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return &x ? x : x + 1'b1;
  endfunction
  assign retire_count = ret_q;
  // next state, next counter values and next timeout flag
  always_comb begin
    nxt      = state;
    hold_n   = hold_cnt;
    drain_n  = drain_cnt;
    halted_n = halted;
    cyc_n    = cycle_count;
    ret_n    = ret_q;
    to_n     = timeout;
    case (state)
      HOLD: begin
        hold_n = hold_cnt + 1'b1;
        if (hold_cnt == HW'(RESET_CYCLES - 1)) nxt = RUN;
      end
      RUN, DRAIN: begin
        cyc_n    = sat_inc(cycle_count);
        halted_n = halted | halt_in;
        drain_n  = drain_cnt + 1'b1;
        for (int i = 0; i < NUM_CH; i++) ret_n[i] = retire_valid[i] ? sat_inc(ret_q[i]) : ret_q[i];
        if (state == RUN) begin
          drain_n = '0;
          if (&halted_n) nxt = DRAIN;
          else if (cyc_n == CNT_W'(MAX_CYCLES)) begin
            nxt  = DONE;
            to_n = 1'b1;
          end
        end else if (drain_cnt == DW'(DRAIN_CYCLES - 1)) nxt = DONE;
      end
      default: if (restart) begin
        nxt      = HOLD;
        hold_n   = '0;
        drain_n  = '0;
        halted_n = '0;
        cyc_n    = '0;
        ret_n    = '0;
        to_n     = 1'b0;
      end
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HOLD;
    else state <= nxt;
  end
  // counters, halt mask and status outputs, all registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      drain_cnt   <= '0;
      halted      <= '0;
      cycle_count <= '0;
      ret_q       <= '0;
      core_reset  <= 1'b1;
      core_run    <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      hold_cnt    <= hold_n;
      drain_cnt   <= drain_n;
      halted      <= halted_n;
      cycle_count <= cyc_n;
      ret_q       <= ret_n;
      core_reset  <= nxt == HOLD;
      core_run    <= nxt == RUN || nxt == DRAIN;
      done        <= nxt == DONE;
      timeout     <= to_n;
    end
  end
endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller: two configurations checked against a cycle-level reference model
module tb_sim_run_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, restart_a, restart_b, halt_b, rv_b;
  logic [1:0] halt_a, rv_a;
  logic cr_a, run_a, done_a, to_a, cr_b, run_b, done_b, to_b;
  logic [1:0] halted_a;
  logic [0:0] halted_b;
  logic [31:0] cyc_a;
  logic [63:0] ret_a;
  logic [3:0] cyc_b, ret_b;
  int checks = 0, errors = 0;
  sim_run_controller #(.NUM_CH(2), .CNT_W(32), .RESET_CYCLES(3), .MAX_CYCLES(92), .DRAIN_CYCLES(4)) u_a (
    .clk(clk), .reset(rst_a), .restart(restart_a), .halt_in(halt_a), .retire_valid(rv_a),
    .core_reset(cr_a), .core_run(run_a), .done(done_a), .timeout(to_a), .halted(halted_a),
    .cycle_count(cyc_a), .retire_count(ret_a));
  sim_run_controller #(.NUM_CH(1), .CNT_W(4), .RESET_CYCLES(1), .MAX_CYCLES(15), .DRAIN_CYCLES(4)) u_b (
    .clk(clk), .reset(rst_b), .restart(restart_b), .halt_in(halt_b), .retire_valid(rv_b),
    .core_reset(cr_b), .core_run(run_b), .done(done_b), .timeout(to_b), .halted(halted_b),
    .cycle_count(cyc_b), .retire_count(ret_b));
  // reference model: phase 0 hold, 1 run, 2 drain, 3 done
  int ph[2];
  longint hold[2], drn[2], cyc[2];
  longint ret[2][2];
  int hlt[2];
  bit mdone[2], mto[2];
  longint lim[2] = '{64'hFFFF_FFFF, 15};
  int nch[2] = '{2, 1};
  int rcy[2] = '{3, 1};
  int mx[2]  = '{92, 15};
  int dcy[2] = '{4, 4};
  task automatic mreset(int k);
    ph[k] = 0; hold[k] = 0; drn[k] = 0; cyc[k] = 0; ret[k][0] = 0; ret[k][1] = 0;
    hlt[k] = 0; mdone[k] = 0; mto[k] = 0;
  endtask
  task automatic mstep(int k, bit rst, bit rs, logic [1:0] h, logic [1:0] r);
    int m = (1 << nch[k]) - 1;
    if (rst) begin
      mreset(k);
      return;
    end
    case (ph[k])
      0: begin
        hold[k]++;
        if (hold[k] == rcy[k]) ph[k] = 1;
      end
      1, 2: begin
        cyc[k] = cyc[k] < lim[k] ? cyc[k] + 1 : lim[k];
        for (int i = 0; i < nch[k]; i++) if (r[i]) ret[k][i] = ret[k][i] < lim[k] ? ret[k][i] + 1 : lim[k];
        hlt[k] = hlt[k] | (int'(h) & m);
        if (ph[k] == 1) begin
          if (hlt[k] == m) begin ph[k] = 2; drn[k] = 0; end
          else if (cyc[k] == mx[k]) begin ph[k] = 3; mdone[k] = 1; mto[k] = 1; end
        end else begin
          drn[k]++;
          if (drn[k] == dcy[k]) begin ph[k] = 3; mdone[k] = 1; end
        end
      end
      default: if (rs) mreset(k);
    endcase
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("a_core_reset", cr_a, ph[0] == 0);
    chk("a_core_run", run_a, ph[0] == 1 || ph[0] == 2);
    chk("a_done", done_a, mdone[0]);
    chk("a_timeout", to_a, mto[0]);
    chk("a_halted", halted_a, hlt[0]);
    chk("a_cycle_count", cyc_a, cyc[0]);
    chk("a_retire0", ret_a[31:0], ret[0][0]);
    chk("a_retire1", ret_a[63:32], ret[0][1]);
    chk("b_core_reset", cr_b, ph[1] == 0);
    chk("b_core_run", run_b, ph[1] == 1 || ph[1] == 2);
    chk("b_done", done_b, mdone[1]);
    chk("b_timeout", to_b, mto[1]);
    chk("b_halted", halted_b, hlt[1]);
    chk("b_cycle_count", cyc_b, cyc[1]);
    chk("b_retire0", ret_b, ret[1][0]);
  endtask
  task automatic tick();
    @(posedge clk);
    mstep(0, rst_a, restart_a, halt_a, rv_a);
    mstep(1, rst_b, restart_b, {1'b0, halt_b}, {1'b0, rv_b});
    #1;
    check_all();
  endtask
  task automatic run_done(int k);
    for (int n = 0; n < 400 && ph[k] != 3; n++) tick();
    if (k == 0) chk("a_wait_done", done_a, 1);
    else chk("b_wait_done", done_b, 1);
  endtask
  task automatic run_to(int k, longint n);
    for (int j = 0; j < 400 && cyc[k] < n; j++) tick();
  endtask
  task automatic restart_ch(int k);
    if (k == 0) restart_a = 1'b1;
    else restart_b = 1'b1;
    tick();
    restart_a = 1'b0;
    restart_b = 1'b0;
  endtask
  initial begin
    rst_a = 1'b1; rst_b = 1'b1; restart_a = 1'b0; restart_b = 1'b0;
    halt_a = '0; rv_a = '0; halt_b = 1'b0; rv_b = 1'b0;
    mreset(0);
    mreset(1);
    tick();
    tick();
    rst_a = 1'b0;
    tick();
    chk("t1_hold_edge1", cr_a, 1);
    tick();
    chk("t1_hold_edge2", cr_a, 1);
    tick();
    chk("t1_release", cr_a, 0);
    chk("t1_run", run_a, 1);
    rv_a = 2'b01;
    run_done(0);
    chk("t2_cycles", cyc_a, 92);
    chk("t2_timeout", to_a, 1);
    repeat (5) tick();
    chk("t2_frozen", cyc_a, 92);
    restart_ch(0);
    rv_a = 2'b11;
    run_to(0, 5);
    restart_a = 1'b1;
    tick();
    tick();
    restart_a = 1'b0;
    chk("t6_restart_ignored", run_a, 1);
    run_to(0, 9);
    halt_a = 2'b01;
    tick();
    halt_a = 2'b00;
    run_to(0, 19);
    halt_a = 2'b10;
    tick();
    halt_a = 2'b00;
    chk("t3_drain_at", cyc_a, 20);
    run_done(0);
    chk("t3_cycles", cyc_a, 24);
    chk("t3_timeout", to_a, 0);
    chk("t3_retire0", ret_a[31:0], 24);
    chk("t3_retire1", ret_a[63:32], 24);
    restart_ch(0);
    run_to(0, 91);
    halt_a = 2'b11;
    tick();
    halt_a = 2'b00;
    chk("t4_cycle", cyc_a, 92);
    chk("t4_drain_run", run_a, 1);
    run_done(0);
    chk("t4_timeout", to_a, 0);
    chk("t4_cycles", cyc_a, 96);
    restart_ch(0);
    run_to(0, 30);
    halt_a = 2'b11;
    tick();
    halt_a = 2'b00;
    tick();
    #3;
    rst_a = 1'b1;
    #1;
    mreset(0);
    check_all();
    chk("t6_async_core_reset", cr_a, 1);
    chk("t6_async_cycles", cyc_a, 0);
    tick();
    rst_a = 1'b0;
    repeat (8) begin
      for (int n = 0; n < 400 && ph[0] != 3; n++) begin
        halt_a = ($urandom_range(0, 24) == 0) ? 2'($urandom) : 2'b00;
        rv_a = 2'($urandom);
        restart_a = ($urandom_range(0, 7) == 0);
        tick();
      end
      halt_a = 2'b00;
      restart_a = 1'b0;
      chk("rand_done", done_a, 1);
      restart_ch(0);
    end
    rst_b = 1'b0;
    rv_b = 1'b1;
    run_done(1);
    chk("t5_cycles", cyc_b, 15);
    chk("t5_retire", ret_b, 15);
    chk("t5_timeout", to_b, 1);
    repeat (3) tick();
    chk("t5_frozen", ret_b, 15);
    restart_ch(1);
    chk("t5_restart_hold", cr_b, 1);
    chk("t5_restart_cycles", cyc_b, 0);
    chk("t5_restart_retire", ret_b, 0);
    chk("t5_restart_done", done_b, 0);
    run_to(1, 13);
    halt_b = 1'b1;
    tick();
    halt_b = 1'b0;
    run_done(1);
    chk("t5_sat_cycles", cyc_b, 15);
    chk("t5_sat_retire", ret_b, 15);
    chk("t5_sat_timeout", to_b, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
